camera_frame_writer: RTL and testbench

- Sequences the camera word stream into DDR through the native (non-AXI) MIG user interface.
- Drives the camera request/grant handshake: one word per transaction.
- Zero-pads each captured word to the MIG data width and issues one write per word at an auto-incrementing address.
- Ping-pongs between two frame buffers on each frame end; sits between the camera source and MIG app_* ports.

---
 rtl/camera_frame_writer_if.sv | 24 ++
 rtl/camera_frame_writer.sv | 129 ++++++++++++
 tb/tb_camera_frame_writer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/camera_frame_writer_if.sv
// rtl/camera_frame_writer_if.sv - MIG native user-interface write port (app_* command and write-data channels)
interface camera_frame_writer_if #(
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_ADDR_WIDTH = 28
);
  logic                      app_en;
  logic [2:0]                app_cmd;
  logic [APP_ADDR_WIDTH-1:0] app_addr;
  logic                      app_rdy;
  logic [APP_DATA_WIDTH-1:0] app_wdf_data;
  logic                      app_wdf_wren;
  logic                      app_wdf_end;
  logic                      app_wdf_rdy;

  modport master (
    output app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy
  );

  modport slave (
    input  app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy
  );
endinterface

// File: rtl/camera_frame_writer.sv
// rtl/camera_frame_writer.sv - camera word stream to MIG native writes with ping-pong frame buffers
// Optional frame size check: define CAMERA_FRAME_WRITER_SIZE_CHECK_EN to add the sticky size_err output.
module camera_frame_writer #(
  parameter int          BUS_WIDTH      = 96,
  parameter int          APP_DATA_WIDTH = 128,
  parameter int          APP_ADDR_WIDTH = 28,
  parameter int          ADDR_STEP      = 8,
  parameter int unsigned BUF0_BASE      = 32'h0000000,
  parameter int unsigned BUF1_BASE      = 32'h0400000,
  parameter int          FRAME_WORDS    = 407040
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_calib_complete,
  input  logic                 enable,
  output logic                 recieve_ready,
  input  logic                 in_progress,
  input  logic [BUS_WIDTH-1:0] data,
  input  logic                 data_valid,
  input  logic                 frame_end,
  camera_frame_writer_if.master app,
  output logic                 active_buf,
  output logic                 frame_done,
  output logic [19:0]          word_cnt
`ifdef CAMERA_FRAME_WRITER_SIZE_CHECK_EN
  ,
  output logic                 size_err
`endif
);

  localparam logic [APP_ADDR_WIDTH-1:0] BASE0 = APP_ADDR_WIDTH'(BUF0_BASE);
  localparam logic [APP_ADDR_WIDTH-1:0] BASE1 = APP_ADDR_WIDTH'(BUF1_BASE);
  localparam logic [APP_ADDR_WIDTH-1:0] STEP  = APP_ADDR_WIDTH'(ADDR_STEP);

  if (APP_DATA_WIDTH < BUS_WIDTH || FRAME_WORDS < 1 || FRAME_WORDS > (1 << 20)) begin : g_bad_params
    $error("camera_frame_writer: invalid parameter set");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

  state_t                    state, state_nxt;
  logic [APP_ADDR_WIDTH-1:0] addr_q;
  logic [APP_DATA_WIDTH-1:0] data_q;
  logic                      fe_cur, fe_prev;
  logic                      cmd_pend, wdf_pend;
  logic                      capture, write_done, frame_edge;

  assign capture    = (state == WAIT) && data_valid && !in_progress;
  // Each channel counts as done once accepted, either in this cycle or earlier.
  assign write_done = (state == WRITE) && (!cmd_pend || app.app_rdy) && (!wdf_pend || app.app_wdf_rdy);
  assign frame_edge = fe_cur && !fe_prev;

  assign recieve_ready    = (state == REQ);
  assign frame_done       = write_done && frame_edge;
  assign app.app_en       = cmd_pend;
  assign app.app_cmd      = 3'b000;
  assign app.app_addr     = addr_q;
  assign app.app_wdf_data = data_q;
  assign app.app_wdf_wren = wdf_pend;
  assign app.app_wdf_end  = wdf_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && init_calib_complete) state_nxt = REQ;
      REQ:     if (in_progress) state_nxt = WAIT;
      WAIT:    if (capture) state_nxt = WRITE;
      WRITE:   if (write_done) state_nxt = enable ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= BASE0;
      data_q     <= '0;
      fe_cur     <= 1'b0;
      fe_prev    <= 1'b0;
      cmd_pend   <= 1'b0;
      wdf_pend   <= 1'b0;
      active_buf <= 1'b0;
      word_cnt   <= '0;
    end else begin
      if (capture) begin
        data_q   <= APP_DATA_WIDTH'(data);
        fe_cur   <= frame_end;
        fe_prev  <= fe_cur;
        cmd_pend <= 1'b1;
        wdf_pend <= 1'b1;
      end else begin
        if (app.app_rdy)     cmd_pend <= 1'b0;
        if (app.app_wdf_rdy) wdf_pend <= 1'b0;
      end

      if (write_done) begin
        if (frame_edge) begin
          active_buf <= !active_buf;
          addr_q     <= active_buf ? BASE0 : BASE1;
          word_cnt   <= '0;
        end else begin
          addr_q     <= addr_q + STEP;
          word_cnt   <= word_cnt + 20'd1;
        end
      end
    end
  end

`ifdef CAMERA_FRAME_WRITER_SIZE_CHECK_EN
  localparam logic [20:0] FRAME_WORDS_W = 21'(FRAME_WORDS);

  // The frame-end word is not yet in word_cnt, hence the +1.
  always_ff @(posedge clk) begin
    if (rst) begin
      size_err <= 1'b0;
    end else if (write_done && frame_edge && (({1'b0, word_cnt} + 21'd1) != FRAME_WORDS_W)) begin
      size_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_camera_frame_writer.sv
// tb/tb_camera_frame_writer.sv - directed self-checking bench for camera_frame_writer
module tb_camera_frame_writer;

  logic        clk;
  logic        rst;
  logic        init_calib_complete;
  logic        enable;
  logic        recieve_ready;
  logic        in_progress;
  logic [95:0] data;
  logic        data_valid;
  logic        frame_end;
  logic        active_buf;
  logic        frame_done;
  logic [19:0] word_cnt;
`ifdef CAMERA_FRAME_WRITER_SIZE_CHECK_EN
  logic        size_err;
`endif

  int errors = 0;
  int checks = 0;

  camera_frame_writer_if #(.APP_DATA_WIDTH(128), .APP_ADDR_WIDTH(28)) app_bus ();

  camera_frame_writer #(
    .BUS_WIDTH(96), .APP_DATA_WIDTH(128), .APP_ADDR_WIDTH(28), .ADDR_STEP(8),
    .BUF0_BASE(32'h0), .BUF1_BASE(32'h0400000), .FRAME_WORDS(4)
  ) dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete), .enable(enable),
    .recieve_ready(recieve_ready), .in_progress(in_progress), .data(data),
    .data_valid(data_valid), .frame_end(frame_end), .app(app_bus),
    .active_buf(active_buf), .frame_done(frame_done), .word_cnt(word_cnt)
`ifdef CAMERA_FRAME_WRITER_SIZE_CHECK_EN
    , .size_err(size_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Camera side: answer REQ, then present one word; returns at the first WRITE cycle.
  task automatic cam_word(input logic [95:0] d, input logic fe);
    int n = 0;
    while (recieve_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", recieve_ready, 1);
    in_progress = 1'b1;
    @(negedge clk);
    in_progress = 1'b0;
    data = d;
    data_valid = 1'b1;
    frame_end = fe;
    @(negedge clk);
    data_valid = 1'b0;
    frame_end = 1'b0;
    data = '0;
  endtask

  task automatic check_write(input string tag, input logic [27:0] a, input logic [95:0] d,
                             input logic fd, input logic [19:0] wc);
    logic [127:0] padded;
    padded = {32'd0, d};
    check({tag, "_app_en"}, app_bus.app_en, 1);
    check({tag, "_wren"}, app_bus.app_wdf_wren, 1);
    check({tag, "_wdf_end"}, app_bus.app_wdf_end, 1);
    check({tag, "_cmd"}, app_bus.app_cmd, 0);
    check({tag, "_addr"}, app_bus.app_addr, a);
    check({tag, "_wdata"}, app_bus.app_wdf_data, padded);
    check({tag, "_frame_done"}, frame_done, fd);
    check({tag, "_word_cnt"}, word_cnt, wc);
  endtask

  initial begin
    int highs;
    logic [95:0] d;

    rst = 1'b1;
    init_calib_complete = 1'b0;
    enable = 1'b0;
    in_progress = 1'b0;
    data = '0;
    data_valid = 1'b0;
    frame_end = 1'b0;
    app_bus.app_rdy = 1'b1;
    app_bus.app_wdf_rdy = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_app_en", app_bus.app_en, 0);
    check("rst_wren", app_bus.app_wdf_wren, 0);
    check("rst_addr", app_bus.app_addr, 0);
    check("rst_wdata", app_bus.app_wdf_data, 0);
    check("rst_recv_ready", recieve_ready, 0);
    check("rst_active_buf", active_buf, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_frame_done", frame_done, 0);
`ifdef CAMERA_FRAME_WRITER_SIZE_CHECK_EN
    check("rst_size_err", size_err, 0);
`endif

    // Calibration gate.
    rst = 1'b0;
    enable = 1'b1;
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (recieve_ready !== 1'b0) highs++;
    end
    check("calib_block_ready_highs", highs, 0);
    init_calib_complete = 1'b1;
    #1 check("calib_rise_same_cycle", recieve_ready, 0);
    @(negedge clk);
    check("calib_first_req", recieve_ready, 1);

    // Three-word frame, always-ready MIG.
    cam_word(96'hFFFF_0000_1111_2222_3333_4444, 1'b0);
    check_write("f0w0", 28'h0000000, 96'hFFFF_0000_1111_2222_3333_4444, 1'b0, 20'd0);
    cam_word(96'h8000_0000_0000_0000_0000_0001, 1'b0);
    check_write("f0w1", 28'h0000008, 96'h8000_0000_0000_0000_0000_0001, 1'b0, 20'd1);
    cam_word(96'hDEAD_BEEF_CAFE_F00D_1234_5678, 1'b1);
    check_write("f0w2", 28'h0000010, 96'hDEAD_BEEF_CAFE_F00D_1234_5678, 1'b1, 20'd2);
    @(negedge clk);
    check("f0_end_active_buf", active_buf, 1);
    check("f0_end_word_cnt", word_cnt, 0);
    check("f0_end_addr", app_bus.app_addr, 28'h0400000);
    check("f0_end_frame_done_low", frame_done, 0);

    // Command channel stalled, data accepted at once.
    app_bus.app_rdy = 1'b0;
    cam_word(96'h0123_4567_89AB_CDEF_0011_2233, 1'b0);
    check_write("bp_w", 28'h0400000, 96'h0123_4567_89AB_CDEF_0011_2233, 1'b0, 20'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_app_en_held", app_bus.app_en, 1);
      check("bp_wren_dropped", app_bus.app_wdf_wren, 0);
      check("bp_addr_stable", app_bus.app_addr, 28'h0400000);
      check("bp_no_req", recieve_ready, 0);
    end
    app_bus.app_rdy = 1'b1;
    @(negedge clk);
    check("bp_done_app_en", app_bus.app_en, 0);
    check("bp_done_req", recieve_ready, 1);
    check("bp_done_addr", app_bus.app_addr, 28'h0400008);
    check("bp_done_word_cnt", word_cnt, 1);

    // Frame end stuck high: only the first one flips the buffer.
    cam_word(96'hAAAA_0000_0000_0000_0000_0004, 1'b1);
    check_write("stk_w4", 28'h0400008, 96'hAAAA_0000_0000_0000_0000_0004, 1'b1, 20'd1);
    for (int i = 0; i < 4; i++) begin
      d = {32'hA5A5_0000 + 32'(i), 64'h5A5A_5A5A_0000_0000};
      cam_word(d, 1'b1);
      check_write("stk_hold", 28'(i * 8), d, 1'b0, 20'(i));
    end
    @(negedge clk);
    check("stk_active_buf", active_buf, 0);
    check("stk_addr", app_bus.app_addr, 28'h0000020);

    // Re-arm with a frame_end=0 word, then a new frame end.
    cam_word(96'h0000_0000_0000_0000_0000_0009, 1'b0);
    check_write("rearm_w9", 28'h0000020, 96'h0000_0000_0000_0000_0000_0009, 1'b0, 20'd4);
    cam_word(96'h0000_0000_0000_0000_0000_000A, 1'b1);
    check_write("rearm_w10", 28'h0000028, 96'h0000_0000_0000_0000_0000_000A, 1'b1, 20'd5);
    @(negedge clk);
    check("rearm_active_buf", active_buf, 1);

    // Reset while a write is stalled on both channels.
    app_bus.app_rdy = 1'b0;
    app_bus.app_wdf_rdy = 1'b0;
    cam_word(96'h0000_0000_0000_0000_0000_000B, 1'b0);
    check("rstw_app_en_before", app_bus.app_en, 1);
    check("rstw_addr_before", app_bus.app_addr, 28'h0400000);
    rst = 1'b1;
    @(negedge clk);
    check("rstw_app_en", app_bus.app_en, 0);
    check("rstw_wren", app_bus.app_wdf_wren, 0);
    check("rstw_addr", app_bus.app_addr, 0);
    check("rstw_active_buf", active_buf, 0);
    check("rstw_word_cnt", word_cnt, 0);
    check("rstw_req", recieve_ready, 0);
    rst = 1'b0;
    app_bus.app_rdy = 1'b1;
    app_bus.app_wdf_rdy = 1'b1;

    // Four-word frame matches FRAME_WORDS=4, then a short three-word frame.
    for (int i = 0; i < 4; i++) begin
      d = {64'hC0DE_0000_0000_0000, 32'(i)};
      cam_word(d, i == 3);
      check_write("sz4", 28'(i * 8), d, i == 3, 20'(i));
    end
    @(negedge clk);
    check("sz4_active_buf", active_buf, 1);
`ifdef CAMERA_FRAME_WRITER_SIZE_CHECK_EN
    check("sz4_size_err", size_err, 0);
`endif
    for (int i = 0; i < 3; i++) begin
      d = {64'hBEEF_0000_0000_0000, 32'(i)};
      cam_word(d, i == 2);
      check_write("sz3", 28'h0400000 + 28'(i * 8), d, i == 2, 20'(i));
    end
    enable = 1'b0;
    @(negedge clk);
    check("sz3_active_buf", active_buf, 0);
    check("sz3_addr", app_bus.app_addr, 0);
    check("dis_app_en", app_bus.app_en, 0);
`ifdef CAMERA_FRAME_WRITER_SIZE_CHECK_EN
    check("sz3_size_err", size_err, 1);
`endif
    repeat (3) @(negedge clk);
    check("dis_idle_no_req", recieve_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
